// File: rtl/ysyx_23060136_idu_gpr_file_mp.sv
// Multi-port general-purpose register file with scoreboard busy bits.
// Reads are combinational and bypass same-cycle writes. x0 is hardwired to zero.
module ysyx_23060136_idu_gpr_file_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NRD*$clog2(NREG)-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]            rd_data,
    output logic [NRD-1:0]                 rd_busy,
    input  logic [NWR-1:0]                 wr_en,
    input  logic [NWR*$clog2(NREG)-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]            wr_data,
    input  logic                           iss_en,
    input  logic [$clog2(NREG)-1:0]        iss_rd,
    input  logic                           flush
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] r_gpr [NREG];
    logic [NREG-1:0] r_busy;

    logic [NREG-1:0] w_wr_hit;
    logic [XLEN-1:0] w_wr_val [NREG];
    logic [NREG-1:0] w_iss_vec;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW-1:0]   w_ra [NRD];

    // Per-register write resolution; later ports override earlier ones.
    always_comb begin
        w_wr_hit = '0;
        for (int a = 0; a < NREG; a++) begin
            w_wr_val[a] = '0;
        end
        for (int a = 1; a < NREG; a++) begin
            for (int j = 0; j < NWR; j++) begin
                w_wr_hit[a] = w_wr_hit[a] |
                              (wr_en[j] & (wr_addr[j*AW +: AW] == AW'(a)));
                w_wr_val[a] = (wr_en[j] & (wr_addr[j*AW +: AW] == AW'(a))) ?
                              wr_data[j*XLEN +: XLEN] : w_wr_val[a];
            end
        end
    end

    // Next busy vector: flush wins; a same-edge issue outranks the write clear.
    always_comb begin
        w_iss_vec = '0;
        if (iss_en && (iss_rd != '0)) begin
            w_iss_vec = {{(NREG-1){1'b0}}, 1'b1} << iss_rd;
        end else begin
            w_iss_vec = '0;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = (r_busy & ~w_wr_hit) | w_iss_vec;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Read ports: zero for x0, bypass on a same-cycle write, else stored value.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra[k] = rd_addr[k*AW +: AW];
            if (w_ra[k] == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end else if (w_wr_hit[w_ra[k]]) begin
                rd_data[k*XLEN +: XLEN] = w_wr_val[w_ra[k]];
                rd_busy[k]              = 1'b0;
            end else begin
                rd_data[k*XLEN +: XLEN] = r_gpr[w_ra[k]];
                rd_busy[k]              = r_busy[w_ra[k]];
            end
        end
    end

    // State update; register 0 is only ever loaded by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            for (int a = 0; a < NREG; a++) begin
                r_gpr[a] <= '0;
            end
        end else begin
            r_busy <= w_busy_nxt;
            for (int a = 1; a < NREG; a++) begin
                if (w_wr_hit[a]) begin
                    r_gpr[a] <= w_wr_val[a];
                end else begin
                    r_gpr[a] <= r_gpr[a];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_idu_gpr_file_mp.sv
// Bench for the multi-port register file: directed vector table, reset
// sequence, then randomized traffic checked against an array-based model.
module tb_ysyx_23060136_idu_gpr_file_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_rd;
    logic                 flush;

    logic [AW-1:0]   ra [NRD];
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];

    assign rd_addr = {ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    ysyx_23060136_idu_gpr_file_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [XLEN-1:0] ref_gpr  [NREG];
    bit              ref_busy [NREG];

    typedef struct {
        logic [1:0]      we;
        logic [AW-1:0]   wa0;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd0;
        logic [XLEN-1:0] wd1;
        logic            ie;
        logic [AW-1:0]   ir;
        logic            fl;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
        logic [1:0]      eb;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < NREG; a++) begin
            ref_gpr[a]  = '0;
            ref_busy[a] = 1'b0;
        end
    endtask

    // What a read of address a should see right now, given the current inputs.
    task automatic model_read(input int a, output logic [XLEN-1:0] d, output logic b);
        bit hit;
        hit = 1'b0;
        d   = ref_gpr[a];
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (int'(wa[j]) == a) && (a != 0)) begin
                hit = 1'b1;
                d   = wd[j];
            end
        end
        b = ref_busy[a] && !hit;
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    // Apply the effect of one clock edge with the current inputs.
    task automatic model_edge();
        bit written [NREG];
        for (int a = 0; a < NREG; a++) written[a] = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] != 0)) begin
                ref_gpr[wa[j]] = wd[j];
                written[wa[j]] = 1'b1;
            end
        end
        if (flush) begin
            for (int a = 0; a < NREG; a++) ref_busy[a] = 1'b0;
        end else begin
            for (int a = 0; a < NREG; a++) if (written[a]) ref_busy[a] = 1'b0;
            if (iss_en && (iss_rd != 0)) ref_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        wr_en  = '0;
        wa[0]  = '0; wa[1] = '0;
        wd[0]  = '0; wd[1] = '0;
        iss_en = 1'b0;
        iss_rd = '0;
        flush  = 1'b0;
        ra[0]  = '0; ra[1] = '0;
    endtask

    initial begin
        logic [XLEN-1:0] md0, md1;
        logic            mb0, mb1;
        n_checks = 0;
        n_fail   = 0;

        tbl[0]  = '{2'b01, 5'd5, 5'd0, 64'h1234, 64'h0,    1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 64'h1234, 64'h0,    2'b00};
        tbl[1]  = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 64'h1234, 64'h0,    2'b00};
        tbl[2]  = '{2'b11, 5'd7, 5'd7, 64'hA,    64'hB,    1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 64'hB,    64'hB,    2'b00};
        tbl[3]  = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 64'hB,    64'h1234, 2'b00};
        tbl[4]  = '{2'b11, 5'd0, 5'd0, 64'hFFFF, 64'hFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 64'h0,    64'h0,    2'b00};
        tbl[5]  = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b1, 5'd3, 1'b0, 5'd3, 5'd0, 64'h0,    64'h0,    2'b00};
        tbl[6]  = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 64'h0,    64'h0,    2'b01};
        tbl[7]  = '{2'b10, 5'd0, 5'd3, 64'h0,    64'h55,   1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 64'h55,   64'h55,   2'b00};
        tbl[8]  = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 64'h55,   64'h0,    2'b00};
        tbl[9]  = '{2'b01, 5'd4, 5'd0, 64'h44,   64'h0,    1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 64'h44,   64'h0,    2'b00};
        tbl[10] = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 5'd0, 1'b0, 5'd4, 5'd4, 64'h44,   64'h44,   2'b11};
        tbl[11] = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b1, 5'd6, 1'b1, 5'd4, 5'd6, 64'h44,   64'h0,    2'b01};
        tbl[12] = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 5'd0, 1'b0, 5'd4, 5'd6, 64'h44,   64'h0,    2'b00};

        idle_inputs();
        rst = 1'b0;
        model_reset();
        #2;
        ra[0] = 5'd5; ra[1] = 5'd31;
        #1;
        chk("reset_data0", rd_data[63:0], 64'h0);
        chk("reset_data1", rd_data[127:64], 64'h0);
        chk("reset_busy", {62'h0, rd_busy}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors: inputs applied on the falling edge, checked before the rising edge.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_en  = tbl[i].we;
            wa[0]  = tbl[i].wa0; wa[1] = tbl[i].wa1;
            wd[0]  = tbl[i].wd0; wd[1] = tbl[i].wd1;
            iss_en = tbl[i].ie;  iss_rd = tbl[i].ir;
            flush  = tbl[i].fl;
            ra[0]  = tbl[i].ra0; ra[1] = tbl[i].ra1;
            #2;
            chk($sformatf("vec%0d_data0", i), rd_data[63:0], tbl[i].e0);
            chk($sformatf("vec%0d_data1", i), rd_data[127:64], tbl[i].e1);
            chk($sformatf("vec%0d_busy", i), {62'h0, rd_busy}, {62'h0, tbl[i].eb});
            model_edge();
        end

        // Mark x12 busy, then pull reset low between edges with traffic asserted.
        @(negedge clk);
        idle_inputs();
        iss_en = 1'b1; iss_rd = 5'd12;
        model_edge();
        @(negedge clk);
        idle_inputs();
        ra[0] = 5'd12; ra[1] = 5'd4;
        #1;
        chk("pre_reset_busy12", {62'h0, rd_busy}, 64'h1);
        chk("pre_reset_x4", rd_data[127:64], 64'h44);
        #1;
        rst    = 1'b0;
        wr_en  = 2'b11;
        wa[0]  = 5'd9;  wa[1] = 5'd10;
        wd[0]  = 64'h99; wd[1] = 64'hAA;
        iss_en = 1'b1;  iss_rd = 5'd9;
        #1;
        chk("midrst_data0", rd_data[63:0], 64'h0);
        chk("midrst_data1", rd_data[127:64], 64'h0);
        chk("midrst_busy", {62'h0, rd_busy}, 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        ra[0] = 5'd9; ra[1] = 5'd10;
        #2;
        chk("postrst_x9", rd_data[63:0], 64'h0);
        chk("postrst_x10", rd_data[127:64], 64'h0);
        chk("postrst_busy", {62'h0, rd_busy}, 64'h0);

        // Randomized traffic with a narrow address window so ports collide often.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int j = 0; j < NWR; j++) begin
                wa[j] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
                wd[j] = {$urandom, $urandom};
            end
            for (int k = 0; k < NRD; k++) begin
                ra[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            end
            wr_en  = 2'($urandom_range(0, 3));
            iss_en = ($urandom_range(0, 1) == 1);
            iss_rd = AW'($urandom_range(0, 7));
            flush  = ($urandom_range(0, 19) == 0);
            #2;
            model_read(int'(ra[0]), md0, mb0);
            model_read(int'(ra[1]), md1, mb1);
            chk($sformatf("rnd%0d_data0", c), rd_data[63:0], md0);
            chk($sformatf("rnd%0d_data1", c), rd_data[127:64], md1);
            chk($sformatf("rnd%0d_busy", c), {62'h0, rd_busy}, {62'h0, mb1, mb0});
            model_edge();
        end

        @(negedge clk);
        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060136_idu_gpr_file_mp.md
YSYX_23060136_IDU_GPR_FILE_MP -- requirements
Module: ysyx_23060136_IDU_GPR_FILE_MP

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG) is derived, not settable.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rd_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy  output  NRD  port k source register has an outstanding producer.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NWR*AW  write addresses, packed as rd_addr.
REQ-012 SHALL have port wr_data  input  NWR*XLEN  write data, packed as rd_data.
REQ-013 SHALL have port iss_en  input  1  instruction issue marks iss_rd pending.
REQ-014 SHALL have port iss_rd  input  AW  destination register of issuing instruction.
REQ-015 SHALL have port flush  input  1  clear all pending marks (pipeline flush).

Function
REQ-016 SHALL hold NREG x XLEN data registers and an NREG-bit busy vector.
REQ-017 SHALL write wr_data[j] into register wr_addr[j] at the clock edge when wr_en[j]=1 and wr_addr[j]!=0.
REQ-018 SHALL, when several enabled write ports target the same address, commit only the highest-index port's data.
REQ-019 SHALL keep register 0 at zero; writes to 0 ignored; busy[0] never set.
REQ-020 SHALL drive rd_data combinationally (0-cycle latency): 0 if rd_addr==0; else the data of the highest-index enabled write port matching rd_addr this cycle (bypass); else the stored value.
REQ-021 SHALL set busy[iss_rd] at the edge when iss_en=1 and iss_rd!=0.
REQ-022 SHALL clear busy[a] at the edge when any enabled write port targets a!=0.
REQ-023 SHALL, on same-edge issue and write to the same register, leave busy set (new producer wins).
REQ-024 SHALL, when flush=1, clear every busy bit at the edge, overriding iss_en; register data and same-cycle writes unaffected.
REQ-025 SHALL drive rd_busy[k] = busy[rd_addr[k]] AND NOT (bypass hit on port k); rd_busy[k]=0 when rd_addr[k]==0.
REQ-026 SHALL have no handshake back-pressure; writes and issues are accepted every cycle.
REQ-027 SHALL support any NRD>=1, NWR>=1 without code change; out-of-range cases need no handling (AW covers NREG exactly).

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all data registers and busy bits; rd_data shows 0, rd_busy shows 0, independent of clk.
REQ-029 SHALL discard writes/issues coincident with rst=0; first update occurs on the first rising edge with rst=1.
REQ-030 SHALL, on reset asserted mid-operation, lose all pending marks and data (no partial state retained).

Verification
REQ-031 SHALL verify: write port0 x5=0x1234 at edge, read rd_addr0=5 next cycle -> rd_data0=0x1234, rd_busy0=0.
REQ-032 SHALL verify: wr_en=11, both addr 7, data 0xA/0xB -> x7=0xB; same-cycle read of 7 shows 0xB.
REQ-033 SHALL verify: write x0=0xFFFF and iss_rd=0 -> rd_data=0, rd_busy=0 on all subsequent reads of 0.
REQ-034 SHALL verify: issue x3, next cycle read 3 -> rd_busy=1; cycle with port1 writing x3=0x55 -> rd_busy=0, rd_data=0x55 (bypass); after edge busy[3]=0.
REQ-035 SHALL verify: issue x4 and write x4 same edge -> busy[4]=1 after; then flush -> busy[4]=0, x4 data retained.
REQ-036 SHALL verify: mid-stream rst low between edges -> all rd_data/rd_busy 0 immediately; writes asserted during reset not stored.
